// File: rtl/wb_hazard_sched_if.sv
// ID-stage hazard bus: decode fields, redirect/freeze controls going in,
// stall/hazard flags and performance counters coming back.
interface wb_hazard_sched_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [2:0]       id_rs;
   logic             id_rs_used;
   logic [2:0]       id_rt;
   logic             id_rt_used;
   logic [2:0]       id_wreg;
   logic             id_reg_en;
   logic             id_mem_en;
   logic             id_mem_wr;
   logic             flush;
   logic             mem_stall;
   logic             id_stall;
   logic             hz_rs;
   logic             hz_rt;
   logic             pipe_freeze;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] lduse_cnt;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wreg,
             id_reg_en, id_mem_en, id_mem_wr, flush, mem_stall,
      input  id_stall, hz_rs, hz_rt, pipe_freeze, stall_cnt, lduse_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wreg,
             id_reg_en, id_mem_en, id_mem_wr, flush, mem_stall,
      output id_stall, hz_rs, hz_rt, pipe_freeze, stall_cnt, lduse_cnt
   );
endinterface

// File: rtl/wb_hazard_sched.sv
// Register-hazard scheduler: a 3-entry scoreboard (EX, MEM, WB) of pending
// register writes. An ID source matching a checked pending write stalls
// ID/IF and bubbles EX; there is no forwarding.
module wb_hazard_sched #(
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input logic              clk,
   input logic              rst_n,
   wb_hazard_sched_if.slave bus
);
   typedef struct packed {
      logic       v;
      logic [2:0] dst;
      logic       ld;
   } ent_t;

   // Index 0 = EX, 1 = MEM, 2 = WB. A write-through register file makes the
   // WB entry harmless, so it drops out of the compare set.
   localparam logic [2:0]       CHK_MASK = WB_BYPASS ? 3'b011 : 3'b111;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   ent_t             r_ent [3];
   logic             r_freeze;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_lduse_cnt;

   logic [2:0] w_hit_rs;
   logic [2:0] w_hit_rt;
   logic [2:0] w_match;
   logic       w_hz_rs;
   logic       w_hz_rt;
   logic       w_stall;
   logic       w_issue;
   logic       w_ld_near;
   ent_t       w_new;

   // Compare both ID sources against every checked, valid entry
   always_comb begin
      w_hit_rs = '0;
      w_hit_rt = '0;
      for (int i = 0; i < 3; i++) begin
         w_hit_rs[i] = CHK_MASK[i] & r_ent[i].v & (r_ent[i].dst == bus.id_rs);
         w_hit_rt[i] = CHK_MASK[i] & r_ent[i].v & (r_ent[i].dst == bus.id_rt);
      end
   end

   assign w_hz_rs = bus.id_valid & bus.id_rs_used & (|w_hit_rs);
   assign w_hz_rt = bus.id_valid & bus.id_rt_used & (|w_hit_rt);
   // A wrong-path ID must neither stall nor enter the pipe.
   assign w_stall = (w_hz_rs | w_hz_rt) & ~bus.flush;
   assign w_issue = bus.id_valid & ~w_stall & ~bus.flush;
   assign w_match = ({3{bus.id_rs_used}} & w_hit_rs) |
                    ({3{bus.id_rt_used}} & w_hit_rt);

   // Load attribution follows the youngest matching producer
   always_comb begin
      w_ld_near = 1'b0;
      if (w_match[0])      w_ld_near = r_ent[0].ld;
      else if (w_match[1]) w_ld_near = r_ent[1].ld;
      else if (w_match[2]) w_ld_near = r_ent[2].ld;
   end

   // Scoreboard entry built from the ID decode fields
   always_comb begin
      w_new.v   = bus.id_reg_en;
      w_new.dst = bus.id_wreg;
      w_new.ld  = bus.id_mem_en & ~bus.id_mem_wr;
   end

   // Shift the scoreboard one stage unless memory freezes the pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) r_ent[i] <= '0;
      end else if (!bus.mem_stall) begin
         r_ent[2] <= r_ent[1];
         r_ent[1] <= r_ent[0];
         r_ent[0] <= w_issue ? w_new : '0;
      end
   end

   // Saturating stall / load-use counters, frozen with the pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_lduse_cnt <= '0;
      end else if (w_stall && !bus.mem_stall) begin
         if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_ld_near && r_lduse_cnt != CNT_MAX) r_lduse_cnt <= r_lduse_cnt + 1'b1;
      end
   end

   // Registered freeze for the debug tap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_freeze <= 1'b0;
      else        r_freeze <= bus.mem_stall;
   end

   assign bus.id_stall    = w_stall;
   assign bus.hz_rs       = w_hz_rs;
   assign bus.hz_rt       = w_hz_rt;
   assign bus.pipe_freeze = r_freeze;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.lduse_cnt   = r_lduse_cnt;
endmodule

// File: tb/tb_wb_hazard_sched.sv
// Bench for wb_hazard_sched: three instances (bypass/16b, no-bypass/16b,
// bypass/4b) share one stimulus stream; each is compared every cycle against
// a queue-based model, plus a vector table and hand-written corner sequences.
module tb_wb_hazard_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       d_vld, d_rsu, d_rtu, d_ren, d_men, d_mwr, d_fl, d_ms;
   logic [2:0] d_rs, d_rt, d_wr;

   wb_hazard_sched_if #(.CNT_W(16)) if_a ();
   wb_hazard_sched_if #(.CNT_W(16)) if_b ();
   wb_hazard_sched_if #(.CNT_W(4))  if_c ();

   assign if_a.id_valid = d_vld, if_a.id_rs = d_rs, if_a.id_rs_used = d_rsu,
          if_a.id_rt = d_rt, if_a.id_rt_used = d_rtu, if_a.id_wreg = d_wr,
          if_a.id_reg_en = d_ren, if_a.id_mem_en = d_men, if_a.id_mem_wr = d_mwr,
          if_a.flush = d_fl, if_a.mem_stall = d_ms;
   assign if_b.id_valid = d_vld, if_b.id_rs = d_rs, if_b.id_rs_used = d_rsu,
          if_b.id_rt = d_rt, if_b.id_rt_used = d_rtu, if_b.id_wreg = d_wr,
          if_b.id_reg_en = d_ren, if_b.id_mem_en = d_men, if_b.id_mem_wr = d_mwr,
          if_b.flush = d_fl, if_b.mem_stall = d_ms;
   assign if_c.id_valid = d_vld, if_c.id_rs = d_rs, if_c.id_rs_used = d_rsu,
          if_c.id_rt = d_rt, if_c.id_rt_used = d_rtu, if_c.id_wreg = d_wr,
          if_c.id_reg_en = d_ren, if_c.id_mem_en = d_men, if_c.id_mem_wr = d_mwr,
          if_c.flush = d_fl, if_c.mem_stall = d_ms;

   wb_hazard_sched #(.WB_BYPASS(1'b1), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   wb_hazard_sched #(.WB_BYPASS(1'b0), .CNT_W(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   wb_hazard_sched #(.WB_BYPASS(1'b1), .CNT_W(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each config keeps a queue of the write records issued into the last three
   // advancing slots, youngest first; freezes simply do not touch it.
   typedef struct packed {logic v; logic [2:0] dst; logic ld;} ment_t;
   ment_t hist [3][$];
   int    m_sc [3];
   int    m_lc [3];
   int    m_pf [3];
   bit    p_stl [3];
   bit    p_ldu [3];
   int    depth [3] = '{2, 3, 2};
   int    cmax  [3] = '{65535, 65535, 15};

   function automatic void mdl_reset();
      for (int k = 0; k < 3; k++) begin
         hist[k].delete();
         for (int j = 0; j < 3; j++) hist[k].push_back('0);
         m_sc[k] = 0; m_lc[k] = 0; m_pf[k] = 0;
      end
   endfunction

   function automatic void mdl_eval(input int k, output bit hrs, output bit hrt,
                                    output bit stl, output bit ldu);
      bit found = 1'b0;
      hrs = 0; hrt = 0; ldu = 0;
      for (int i = 0; i < depth[k]; i++) begin
         ment_t e = hist[k][i];
         bit mrs = e.v && d_rsu && (e.dst == d_rs);
         bit mrt = e.v && d_rtu && (e.dst == d_rt);
         if (mrs) hrs = 1;
         if (mrt) hrt = 1;
         if (!found && (mrs || mrt)) begin found = 1; ldu = e.ld; end
      end
      hrs = hrs && d_vld;
      hrt = hrt && d_vld;
      stl = (hrs || hrt) && !d_fl;
   endfunction

   function automatic void dut_out(input int k, output int st, output int hr, output int ht,
                                   output int sc, output int lc, output int pf);
      case (k)
         0: begin st = int'(if_a.id_stall); hr = int'(if_a.hz_rs); ht = int'(if_a.hz_rt);
                  sc = int'(if_a.stall_cnt); lc = int'(if_a.lduse_cnt); pf = int'(if_a.pipe_freeze); end
         1: begin st = int'(if_b.id_stall); hr = int'(if_b.hz_rs); ht = int'(if_b.hz_rt);
                  sc = int'(if_b.stall_cnt); lc = int'(if_b.lduse_cnt); pf = int'(if_b.pipe_freeze); end
         default: begin st = int'(if_c.id_stall); hr = int'(if_c.hz_rs); ht = int'(if_c.hz_rt);
                  sc = int'(if_c.stall_cnt); lc = int'(if_c.lduse_cnt); pf = int'(if_c.pipe_freeze); end
      endcase
   endfunction

   // sample at the falling edge, compare every instance against the model
   task automatic at_neg();
      int st, hr, ht, sc, lc, pf;
      bit hrs, hrt;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         mdl_eval(k, hrs, hrt, p_stl[k], p_ldu[k]);
         dut_out(k, st, hr, ht, sc, lc, pf);
         chk($sformatf("id_stall[%0d]", k), st, int'(p_stl[k]));
         chk($sformatf("hz_rs[%0d]", k), hr, int'(hrs));
         chk($sformatf("hz_rt[%0d]", k), ht, int'(hrt));
         chk($sformatf("stall_cnt[%0d]", k), sc, m_sc[k]);
         chk($sformatf("lduse_cnt[%0d]", k), lc, m_lc[k]);
         chk($sformatf("pipe_freeze[%0d]", k), pf, m_pf[k]);
      end
   endtask

   task automatic at_pos();
      ment_t ne;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (!d_ms) begin
            if (p_stl[k] && m_sc[k] < cmax[k]) m_sc[k]++;
            if (p_stl[k] && p_ldu[k] && m_lc[k] < cmax[k]) m_lc[k]++;
            ne = '0;
            if (d_vld && !p_stl[k] && !d_fl) ne = '{v: d_ren, dst: d_wr, ld: d_men && !d_mwr};
            hist[k].push_front(ne);
            void'(hist[k].pop_back());
         end
         m_pf[k] = int'(d_ms);
      end
      #1;
   endtask

   task automatic cyc();
      at_neg();
      at_pos();
   endtask

   task automatic drv(input int vld, input int rs, input int rsu, input int rt, input int rtu,
                      input int wr, input int ren, input int men, input int mwr,
                      input int fl, input int ms);
      d_vld = vld[0]; d_rs = rs[2:0]; d_rsu = rsu[0]; d_rt = rt[2:0]; d_rtu = rtu[0];
      d_wr = wr[2:0]; d_ren = ren[0]; d_men = men[0]; d_mwr = mwr[0]; d_fl = fl[0]; d_ms = ms[0];
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // called just after a rising edge; releases well before the next falling edge
   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      mdl_reset();
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int vld, rs, rsu, rt, rtu, wr, ren, men, mwr;
      int a_st, a_rs, a_rt, b_st, b_rs, b_rt;
   } vec_t;
   vec_t tbl [9];

   initial begin
      int st, hr, ht, sc, lc, pf, n;

      // ADDI r3; ADD r4<-r3 (x3); LD r5; OR r6<-r4,r5 (x3); NOP
      tbl[0] = '{1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0,  0, 0, 0};
      tbl[1] = '{1, 3, 1, 0, 0, 4, 1, 0, 0,  1, 1, 0,  1, 1, 0};
      tbl[2] = '{1, 3, 1, 0, 0, 4, 1, 0, 0,  1, 1, 0,  1, 1, 0};
      tbl[3] = '{1, 3, 1, 0, 0, 4, 1, 0, 0,  0, 0, 0,  1, 1, 0};
      tbl[4] = '{1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0,  0, 0, 0};
      tbl[5] = '{1, 4, 1, 5, 1, 6, 1, 0, 0,  1, 1, 1,  1, 0, 1};
      tbl[6] = '{1, 4, 1, 5, 1, 6, 1, 0, 0,  1, 0, 1,  1, 0, 1};
      tbl[7] = '{1, 4, 1, 5, 1, 6, 1, 0, 0,  0, 0, 0,  1, 0, 1};
      tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0};

      idle();
      mdl_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      at_neg();                          // reset state
      chk("rst_stall_cnt", int'(if_a.stall_cnt), 0);
      at_pos();

      for (int i = 0; i < 9; i++) begin
         drv(tbl[i].vld, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
             tbl[i].wr, tbl[i].ren, tbl[i].men, tbl[i].mwr, 0, 0);
         at_neg();
         chk($sformatf("tbl%0d_a_stall", i), int'(if_a.id_stall), tbl[i].a_st);
         chk($sformatf("tbl%0d_a_hzrs", i),  int'(if_a.hz_rs),    tbl[i].a_rs);
         chk($sformatf("tbl%0d_a_hzrt", i),  int'(if_a.hz_rt),    tbl[i].a_rt);
         chk($sformatf("tbl%0d_b_stall", i), int'(if_b.id_stall), tbl[i].b_st);
         chk($sformatf("tbl%0d_b_hzrs", i),  int'(if_b.hz_rs),    tbl[i].b_rs);
         chk($sformatf("tbl%0d_b_hzrt", i),  int'(if_b.hz_rt),    tbl[i].b_rt);
         at_pos();
      end
      chk("tbl_a_stall_cnt", int'(if_a.stall_cnt), 4);
      chk("tbl_a_lduse_cnt", int'(if_a.lduse_cnt), 2);
      chk("tbl_b_stall_cnt", int'(if_b.stall_cnt), 6);
      chk("tbl_b_lduse_cnt", int'(if_b.lduse_cnt), 3);

      // reset asserted while stalled
      do_reset();
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      cyc();
      drv(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
      #1;
      chk("pre_rst_stall", int'(if_a.id_stall), 1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         dut_out(k, st, hr, ht, sc, lc, pf);
         chk($sformatf("rst_mid_out[%0d]", k), st | hr | ht | sc | lc | pf, 0);
      end
      mdl_reset();
      rst_n = 1'b1;
      drv(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
      at_neg();
      chk("post_rst_nostall", int'(if_a.id_stall), 0);
      at_pos();

      // memory freeze while the consumer waits
      do_reset();
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      cyc();
      n = 0;
      for (int i = 0; i < 7; i++) begin
         drv(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, (i < 4) ? 1 : 0);
         at_neg();
         if (if_a.id_stall) n++;
         if (i == 4) chk("freeze_pf_delayed", int'(if_a.pipe_freeze), 1);
         at_pos();
      end
      chk("freeze_stall_cycles", n, 6);
      chk("freeze_stall_cnt", int'(if_a.stall_cnt), 2);

      // flush coinciding with a hazard
      do_reset();
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      cyc();
      drv(1, 3, 1, 0, 0, 3, 1, 0, 0, 1, 0);
      at_neg();
      chk("flush_stall", int'(if_a.id_stall), 0);
      chk("flush_hzrs", int'(if_a.hz_rs), 1);
      at_pos();
      drv(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
      at_neg();
      chk("flush_mem_hit", int'(if_a.id_stall), 1);
      at_pos();
      cyc();

      // ST vs STU
      do_reset();
      drv(1, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0);
      cyc();
      drv(1, 2, 1, 0, 0, 6, 1, 0, 0, 0, 0);
      at_neg();
      chk("st_nostall", int'(if_a.id_stall), 0);
      at_pos();
      do_reset();
      drv(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0);
      cyc();
      drv(1, 0, 0, 2, 1, 6, 1, 0, 0, 0, 0);
      at_neg();
      chk("stu_stall", int'(if_a.id_stall), 1);
      at_pos();
      cyc();
      chk("stu_lduse", int'(if_a.lduse_cnt), 0);

      // saturation: r1 <- r1 chain stalls 2 of every 3 cycles
      do_reset();
      drv(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) cyc();
      chk("sat_c_stall_cnt", int'(if_c.stall_cnt), 15);
      chk("sat_a_stall_cnt", int'(if_a.stall_cnt), 20);
      for (int i = 0; i < 6; i++) cyc();
      chk("sat_c_hold", int'(if_c.stall_cnt), 15);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drv(($urandom_range(0, 7) != 0) ? 1 : 0,
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0,
             $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0) ? 1 : 0,
             ($urandom_range(0, 5) == 0) ? 1 : 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
